// File: rtl/serial_four_bit_adder_pkg.sv
// rtl/serial_four_bit_adder_pkg.sv - shared constants and FSM encoding for the serial adder
package serial_four_bit_adder_pkg;

  // Pick a bit-counter width that can address every operand bit, never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell time-shared by the serial adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_four_bit_adder.sv
// rtl/serial_four_bit_adder.sv - bit-serial adder, one operand bit per clock through one full adder
module serial_four_bit_adder
  import serial_four_bit_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_full_adder (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Partial result with the current bit merged in; the last step publishes this whole word.
  always_comb begin
    acc_next      = acc;
    acc_next[cnt] = fa_s;
  end

  // Control FSM: capture operands on start, walk the bits, publish result and pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_four_bit_adder.md
SERIAL_FOUR_BIT_ADDER -- requirements
Module: serial_four_bit_adder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with the clock port named clk and the reset port named rst_n.
REQ-002 Parameter: WIDTH, default 4, operand width in bits; all other requirements are stated for WIDTH=4.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-006 Port: a  input  4  augend; captured when start is accepted.
REQ-007 Port: b  input  4  addend; captured when start is accepted.
REQ-008 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-009 Port: busy  output  1  high while bits are being processed.
REQ-010 Port: done  output  1  single-cycle pulse; result valid.
REQ-011 Port: sum  output  4  registered result (a+b+cin) mod 16.
REQ-012 Port: cout  output  1  registered carry-out of the 4-bit addition.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: capture a, b and cin; clear the bit counter to 0; enter SHIFT.
REQ-015 In SHIFT, each rising edge SHALL add operand bit[i] plus the running carry through one full-adder cell, store the sum bit at position i, update the carry and increment i.
REQ-016 The last SHIFT edge (i=3) SHALL write the assembled 4-bit result to sum, write the final carry to cout, and enter DONE.
REQ-017 Latency: start is accepted at edge k; done SHALL be high for exactly the cycle between edges k+4 and k+5.
REQ-018 busy SHALL be 1 exactly while the FSM is in SHIFT (4 cycles per operation).
REQ-019 From DONE, the FSM SHALL enter IDLE at the next edge when start=0, or SHIFT when start=1 (back-to-back operation, no idle gap).
REQ-020 start while in SHIFT SHALL be ignored: no recapture and no effect on the result in progress.
REQ-021 sum and cout SHALL change only at the REQ-016 edge and SHALL otherwise hold the last result, including throughout a subsequent operation.
REQ-022 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-023 The carry-out SHALL reflect the full 5-bit result: {cout,sum} = a + b + cin for all 512 input combinations.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, captured operands=0.
REQ-025 Reset asserted during SHIFT SHALL abort the operation, with no done pulse and no update of sum or cout.
REQ-026 After rst_n is released, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the WIDTH default, the FSM state typedef/encoding (IDLE, SHIFT, DONE) and the counter width constant.
REQ-028 The single-bit sum and carry logic SHALL be a sub-module named full_adder (a, b, cin -> s, cout), instantiated once and time-shared across bits.

Verification
REQ-029 Directed scenarios:
- Reset then idle: sum=0, cout=0, busy=0, done=0.
- a=0011, b=0101, cin=0: done 4 cycles after start; sum=1000, cout=0.
- a=1111, b=0001, cin=0: sum=0000, cout=1; then a=1111, b=1111, cin=1: sum=1111, cout=1.
- Back-to-back: start held high through DONE with a=0001, b=0001, cin=1 -> next sum=0011 with no idle cycle; a mid-SHIFT start pulse is ignored.
- rst_n pulsed low in the third SHIFT cycle: busy=0 at once, no done, sum and cout=0; the next op a=0110, b=0111, cin=1 gives sum=1110, cout=0.
- Exhaustive: all 16x16x2 combinations checked against {1'b0,a}+{1'b0,b}+cin, with a, b and cin randomized mid-operation.
